// File: rtl/bcd_seq_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first, start/done handshake.
// Optional invalid-digit detection is built when BCD_INVALID_DETECT_EN is defined.
module bcd_seq_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            sub_q, c_q, cout_q;

  logic [3:0]      ad, braw, bd, digit;
  logic [4:0]      t;
  logic            c_next;
  logic            last;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last)  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign cout  = cout_q;

  // Subtraction adds the nines' complement of B; the borrow travels as an inverted carry.
  assign ad   = a_q[4*k_q +: 4];
  assign braw = b_q[4*k_q +: 4];
  assign bd   = sub_q ? (4'd9 - braw) : braw;
  assign t    = 5'(ad) + 5'(bd) + 5'(c_q);
  assign last = (k_q == KW'(DIGITS - 1));

  always_comb begin
    digit  = t[3:0];
    c_next = 1'b0;
    if (t > 5'd9) begin
      digit  = t[3:0] + 4'd6;
      c_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      c_q    <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sub_q  <= sub;
            c_q    <= sub ? ~cin : cin;
            k_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
          end
        end
        StRun: begin
          sum_q[4*k_q +: 4] <= digit;
          c_q               <= c_next;
          k_q               <= k_q + 1'b1;
          if (last) cout_q  <= sub_q ? ~c_next : c_next;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_INVALID_DETECT_EN
  logic err_q;

  // Sticky per operation; checks raw B, before complementing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      err_q <= 1'b0;
    end else if (state_q == StRun && (ad > 4'd9 || braw > 4'd9)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
